// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the block-copy controller.
package mem_copy_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CYCLES_PER_WORD = 3;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        CHECK = S_CHECK,
        RD    = S_RD,
        CAPT  = S_CAPT,
        WR    = S_WR,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/mem_copy_ctrl_range_check.sv
// Combinational bounds test: base+len evaluated one bit wider so it cannot wrap.
module mem_range_check #(
    parameter int addrSize = 8,
    parameter int size     = 100
) (
    input  logic [addrSize-1:0] base,
    input  logic [addrSize-1:0] len,
    output logic                oor
);
    localparam logic [addrSize:0] LIMIT = (addrSize+1)'(size);

    logic [addrSize:0] sum;

    assign sum = {1'b0, base} + {1'b0, len};
    assign oor = sum > LIMIT;
endmodule

// File: rtl/mem_copy_ctrl.sv
// Ascending block copy through a single-port memory, 3 cycles per word.
// Optional checksum accumulator: define MEM_COPY_CHECKSUM_EN.
module mem_copy_ctrl
    import mem_copy_pkg::*;
#(
    parameter int width    = 8,
    parameter int addrSize = 8,
    parameter int size     = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [addrSize-1:0] srcAddr,
    input  logic [addrSize-1:0] dstAddr,
    input  logic [addrSize-1:0] len,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [width-1:0]    checksum,
    output logic                memWrite,
    output logic [addrSize-1:0] memAddr,
    output logic [width-1:0]    memWrData,
    input  logic [width-1:0]    memRdData
);

    state_t              state;
    logic [addrSize-1:0] src;
    logic [addrSize-1:0] dst;
    logic [addrSize-1:0] cnt;
    logic [addrSize-1:0] idx;
    logic [addrSize-1:0] idx_nxt;
    logic [width-1:0]    data;
    logic                src_oor;
    logic                dst_oor;

    mem_range_check #(.addrSize(addrSize), .size(size)) u_src_chk (
        .base (src),
        .len  (cnt),
        .oor  (src_oor)
    );

    mem_range_check #(.addrSize(addrSize), .size(size)) u_dst_chk (
        .base (dst),
        .len  (cnt),
        .oor  (dst_oor)
    );

    assign idx_nxt   = idx + 1'b1;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign memWrite  = state == WR;
    assign memWrData = data;

    // memAddr is loaded one state ahead so it is stable for the whole RD/CAPT/WR cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            cnt     <= '0;
            idx     <= '0;
            data    <= '0;
            error   <= 1'b0;
            memAddr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src   <= srcAddr;
                        dst   <= dstAddr;
                        cnt   <= len;
                        idx   <= '0;
                        error <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (src_oor || dst_oor) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        memAddr <= src;
                        state   <= RD;
                    end
                end
                RD: state <= CAPT;
                CAPT: begin
                    data    <= memRdData;
                    memAddr <= dst + idx;
                    state   <= WR;
                end
                WR: begin
                    idx <= idx_nxt;
                    if (idx_nxt == cnt) begin
                        state <= DONE;
                    end else begin
                        memAddr <= src + idx_nxt;
                        state   <= RD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == CAPT) begin
            checksum <= checksum + memRdData;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Directed bench for mem_copy_ctrl with a behavioural byte memory.
module tb_mem_copy_ctrl;
    import mem_copy_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] checksum;
    logic       memWrite;
    logic [7:0] memAddr;
    logic [7:0] memWrData;
    logic [7:0] memRdData;

    logic [7:0] mem [0:99];

    int errs   = 0;
    int checks = 0;

    int done_cyc;
    int done_cnt;
    int wr_cnt;
    int busy_c1;
    logic err_at_done;
    logic rs_busy;
    logic rs_wr;

    always #5 clk = ~clk;

    assign memRdData = (memAddr < 8'd100) ? mem[memAddr] : 8'h00;

    mem_copy_ctrl #(.width(8), .addrSize(8), .size(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum),
        .memWrite  (memWrite),
        .memAddr   (memAddr),
        .memWrData (memWrData),
        .memRdData (memRdData)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the cycle after the accepting edge; memory writes land during WR.
    task automatic run(input int s, input int d, input int l,
                       input int restart_at, input int reset_at);
        done_cyc    = -1;
        done_cnt    = 0;
        wr_cnt      = 0;
        busy_c1     = 0;
        err_at_done = 1'b0;
        rs_busy     = 1'b1;
        rs_wr       = 1'b1;
        @(negedge clk);
        srcAddr = 8'(s);
        dstAddr = 8'(d);
        len     = 8'(l);
        start   = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 60; c++) begin
            if (c == 1) busy_c1 = int'(busy);
            if (memWrite) begin
                wr_cnt++;
                if (memAddr < 8'd100) mem[memAddr] = memWrData;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = error;
                end
            end
            if (c == reset_at + 1) begin
                rs_busy = busy;
                rs_wr   = memWrite;
            end
            start = (c == restart_at);
            rst_n = (c != reset_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ck_full;
        logic [7:0] ck_ovl;
`ifdef MEM_COPY_CHECKSUM_EN
        ck_full = 8'd110;
        ck_ovl  = 8'd2;
`else
        ck_full = 8'd0;
        ck_ovl  = 8'd0;
`endif
        for (int k = 0; k < 100; k++) mem[k] = 8'(k) ^ 8'hA5;
        rst_n   = 1'b0;
        start   = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cksum", checksum, 0);
        chk("rst_wr", memWrite, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_wdata", memWrData, 0);
        rst_n = 1'b1;

        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;
        run(0, 10, 4, 0, 0);
        chk("cp_busy_c1", busy_c1, 1);
        chk("cp_done_cyc", done_cyc, CYCLES_PER_WORD * 4 + 2);
        chk("cp_error", err_at_done, 0);
        chk("cp_writes", wr_cnt, 4);
        chk("cp_m10", mem[10], 11);
        chk("cp_m11", mem[11], 22);
        chk("cp_m12", mem[12], 33);
        chk("cp_m13", mem[13], 44);
        chk("cp_cksum", checksum, ck_full);
        chk("cp_idle", busy, 0);

        run(5, 6, 0, 0, 0);
        chk("z_done_cyc", done_cyc, 2);
        chk("z_writes", wr_cnt, 0);
        chk("z_error", err_at_done, 0);
        chk("z_m6", mem[6], 8'd6 ^ 8'hA5);

        run(98, 20, 3, 0, 0);
        chk("oor_error", err_at_done, 1);
        chk("oor_done_cyc", done_cyc, 2);
        chk("oor_writes", wr_cnt, 0);
        chk("oor_held", error, 1);

        run(0, 97, 3, 0, 0);
        chk("edge_error", err_at_done, 0);
        chk("edge_done_cyc", done_cyc, 11);
        chk("edge_m97", mem[97], 11);
        chk("edge_m99", mem[99], 33);

        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
        run(0, 1, 2, 0, 0);
        chk("ovl_m1", mem[1], 1);
        chk("ovl_m2", mem[2], 1);
        chk("ovl_cksum", checksum, ck_ovl);

        run(20, 30, 4, 3, 0);
        chk("rs_dones", done_cnt, 1);
        chk("rs_done_cyc", done_cyc, 14);
        chk("rs_m33", mem[33], 8'd23 ^ 8'hA5);

        mem[40] = 8'd5; mem[41] = 8'd6; mem[42] = 8'd7; mem[43] = 8'd8;
        mem[50] = 8'hEE; mem[51] = 8'hEE; mem[52] = 8'hEE; mem[53] = 8'hEE;
        run(40, 50, 4, 0, 7);
        chk("mr_busy", rs_busy, 0);
        chk("mr_wr", rs_wr, 0);
        chk("mr_dones", done_cnt, 0);
        chk("mr_m50", mem[50], 5);
        chk("mr_m51", mem[51], 6);
        chk("mr_m52", mem[52], 8'hEE);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
